// File: rtl/mul_result_fifo_acc.sv
// rtl/mul_result_fifo_acc.sv - multiplier result FIFO with optional accumulate/flush stage
module mul_result_fifo_acc #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic             acc_en,
    input  logic             acc_flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] acc_value,
    output logic             acc_ovf,
    output logic             flush_stall
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;
    logic             ovf;

    logic             accept;
    logic             acc_take;
    logic             flush_ok;
    logic             push;
    logic             pop;
    logic [WIDTH:0]   acc_sum;
    logic [WIDTH-1:0] push_data;

    assign full        = (cnt == CW'(DEPTH));
    assign empty       = (cnt == '0);
    assign count       = cnt;
    assign acc_value   = acc;
    assign acc_ovf     = ovf;

    // A pass-through flush occupies the write port, so the producer is held off.
    assign in_ready    = !full && !(acc_flush && !acc_en);
    assign accept      = in_valid && in_ready;
    assign acc_take    = accept && acc_en;

    assign out_valid   = !empty;
    assign out_result  = empty ? '0 : mem[rd_ptr];
    assign pop         = out_valid && out_ready;

    // The sum includes any same-cycle accepted product so a flush never loses it.
    assign acc_sum     = {1'b0, acc} + (acc_take ? {1'b0, in_result} : '0);
    assign flush_ok    = acc_flush && !full;
    assign flush_stall = acc_flush && full;
    assign push        = flush_ok || (accept && !acc_en);
    assign push_data   = acc_flush ? acc_sum[WIDTH-1:0] : in_result;

    always_ff @(posedge clk) begin
        if (push && reset_n) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            acc    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            cnt <= cnt + (push ? CW'(1) : CW'(0)) - (pop ? CW'(1) : CW'(0));
            if (flush_ok) begin
                acc <= '0;
                ovf <= 1'b0;
            end else begin
                acc <= acc_sum[WIDTH-1:0];
                ovf <= ovf | acc_sum[WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_mul_result_fifo_acc.sv
// tb/tb_mul_result_fifo_acc.sv - randomized and directed bench for mul_result_fifo_acc
module tb_mul_result_fifo_acc;

    localparam int WIDTH = 64;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_result;
    logic             acc_en;
    logic             acc_flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic [WIDTH-1:0] acc_value;
    logic             acc_ovf;
    logic             flush_stall;

    always #5 clk = ~clk;

    mul_result_fifo_acc #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .acc_en     (acc_en),
        .acc_flush  (acc_flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .acc_value  (acc_value),
        .acc_ovf    (acc_ovf),
        .flush_stall(flush_stall)
    );

    int               n_vec = 0;
    int               n_bad = 0;
    bit               armed = 1'b0;
    logic [WIDTH-1:0] ref_q[$];
    logic [WIDTH-1:0] ref_acc = '0;
    logic             ref_ovf = 1'b0;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, compare all outputs against the reference, then advance the reference.
    task automatic cyc(input logic rn, input logic iv, input logic [WIDTH-1:0] d,
                       input logic ae, input logic fl, input logic ordy);
        logic           is_full, rdy, take, fl_ok, do_pop, do_push;
        logic [WIDTH:0] sum;
        reset_n = rn; in_valid = iv; in_result = d; acc_en = ae; acc_flush = fl; out_ready = ordy;
        #1;
        is_full = (ref_q.size() == DEPTH);
        rdy     = !is_full && !(fl && !ae);
        take    = iv && rdy && ae;
        sum     = {1'b0, ref_acc} + (take ? {1'b0, d} : 65'd0);
        fl_ok   = fl && !is_full;
        do_pop  = ordy && (ref_q.size() > 0);
        do_push = fl_ok || (iv && rdy && !ae);
        if (armed) begin
            chk("in_ready", in_ready, rdy);
            chk("out_valid", out_valid, ref_q.size() > 0);
            chk("out_result", out_result, (ref_q.size() > 0) ? ref_q[0] : '0);
            chk("count", count, ref_q.size());
            chk("full", full, is_full);
            chk("empty", empty, ref_q.size() == 0);
            chk("acc_value", acc_value, ref_acc);
            chk("acc_ovf", acc_ovf, ref_ovf);
            chk("flush_stall", flush_stall, fl && is_full);
        end
        @(posedge clk);
        if (!rn) begin
            ref_q.delete();
            ref_acc = '0;
            ref_ovf = 1'b0;
        end else begin
            if (do_pop) void'(ref_q.pop_front());
            if (do_push) ref_q.push_back(fl ? sum[WIDTH-1:0] : d);
            if (fl_ok) begin
                ref_acc = '0;
                ref_ovf = 1'b0;
            end else begin
                ref_acc = sum[WIDTH-1:0];
                ref_ovf = ref_ovf | sum[WIDTH];
            end
        end
        #1;
    endtask

    task automatic idle(input logic ordy);
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, ordy);
    endtask

    initial begin
        logic [WIDTH-1:0] v;
        reset_n = 1'b0; in_valid = 1'b0; in_result = '0;
        acc_en = 1'b0; acc_flush = 1'b0; out_ready = 1'b0;

        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        armed = 1'b1;
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("rst_empty", empty, 1);
        chk("rst_out_result", out_result, 0);

        // Pass-through, then drain in order
        cyc(1'b1, 1'b1, 64'h12, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 64'h34, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 64'h56, 1'b0, 1'b0, 1'b0);
        chk("pt_count", count, 3);
        chk("pt_head", out_result, 64'h12);
        for (int i = 0; i < 3; i++) idle(1'b1);
        chk("pt_drained", empty, 1);

        // Fill, refuse a fifth, then pop2/push2 across the wrap
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 64'hA0 + i, 1'b0, 1'b0, 1'b0);
        chk("fill_full", full, 1);
        cyc(1'b1, 1'b1, 64'hEE, 1'b0, 1'b0, 1'b0);
        chk("fill_count", count, 4);
        for (int r = 0; r < 3; r++) begin
            idle(1'b1); idle(1'b1);
            cyc(1'b1, 1'b1, 64'hB0 + 2 * r, 1'b0, 1'b0, 1'b0);
            cyc(1'b1, 1'b1, 64'hB1 + 2 * r, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 4; i++) idle(1'b1);

        // Accumulate 3+5+7, flush with a same-cycle 1
        cyc(1'b1, 1'b1, 64'd3, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 64'd5, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 64'd7, 1'b1, 1'b0, 1'b0);
        chk("acc_15", acc_value, 64'd15);
        cyc(1'b1, 1'b1, 64'd1, 1'b1, 1'b1, 1'b0);
        chk("flush_head", out_result, 64'd16);
        chk("flush_acc", acc_value, 0);
        idle(1'b1);

        // Overflow, blocked flush, retry after a pop
        cyc(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 64'd2, 1'b1, 1'b0, 1'b0);
        chk("ovf_acc", acc_value, 64'd1);
        chk("ovf_flag", acc_ovf, 1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 64'hC0 + i, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        chk("stall_flag", flush_stall, 1);
        chk("stall_acc", acc_value, 64'd1);
        chk("stall_count", count, 4);
        idle(1'b1);
        cyc(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        chk("reflush_ovf", acc_ovf, 0);
        for (int i = 0; i < 3; i++) idle(1'b1);
        chk("reflush_head", out_result, 64'd1);
        idle(1'b1);

        // Steady push+pop at count 2, then mid-stream reset
        cyc(1'b1, 1'b1, 64'hD0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 64'hD1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 64'hD2 + i, 1'b0, 1'b0, 1'b1);
        chk("pp_count", count, 2);
        cyc(1'b1, 1'b1, 64'd9, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 64'hE0, 1'b0, 1'b0, 1'b1);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_acc", acc_value, 0);
        chk("mid_rst_valid", out_valid, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(3))
                0: v = 64'hFFFF_FFFF_FFFF_FFFF - WIDTH'($urandom_range(7));
                1: v = WIDTH'($urandom_range(255));
                default: v = {$urandom, $urandom};
            endcase
            cyc(($urandom_range(199) != 0), ($urandom_range(3) != 0), v,
                $urandom_range(1), ($urandom_range(5) == 0), ($urandom_range(2) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
